// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the register-file read path.
//   DATA_W_DEF : default register / read-data width
//   NUM_REGS   : register-file depth (R0-R7)
//   SEL_W      : register index width
//   rdState_t  : state of the one-entry read output buffer
package cpu_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int NUM_REGS   = 8;
  localparam int SEL_W      = 3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rdState_t;
endpackage

// File: rtl/reg_mux8.sv
// reg_mux8: combinational 8:1 register select.
//   iRegs : packed register-file contents, entry n = Rn
//   iSel  : register index
//   oData : selected register value
module reg_mux8
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [NUM_REGS-1:0][DATA_W-1:0] iRegs,
  input  logic [SEL_W-1:0]                iSel,
  output logic [DATA_W-1:0]               oData
);
  always_comb oData = iRegs[iSel];
endmodule

// File: rtl/reg_read_port.sv
// reg_read_port: register-file read port with a one-entry registered output
// buffer and ready/valid handshakes on both sides.
//   iClk, iRst_n        : clock, synchronous active-low reset
//   iR0..iR7            : current register-file outputs
//   iWrEn, iWrData      : register-file write in the same cycle (bypass only)
//   iReqValid/oReqReady : read request handshake, iReqSel = register index
//   oRdValid/iRdReady   : read response handshake, oRdData/oRdSel = payload
// Build option: define REG_READ_BYPASS_EN to forward a same-cycle write to
// the selected register into the read data (write-through). Without it the
// pre-write register value is returned and iWrEn/iWrData are unused.
module reg_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [DATA_W-1:0]   iR0,
  input  logic [DATA_W-1:0]   iR1,
  input  logic [DATA_W-1:0]   iR2,
  input  logic [DATA_W-1:0]   iR3,
  input  logic [DATA_W-1:0]   iR4,
  input  logic [DATA_W-1:0]   iR5,
  input  logic [DATA_W-1:0]   iR6,
  input  logic [DATA_W-1:0]   iR7,
  input  logic [NUM_REGS-1:0] iWrEn,
  input  logic [DATA_W-1:0]   iWrData,
  input  logic                iReqValid,
  input  logic [SEL_W-1:0]    iReqSel,
  output logic                oReqReady,
  output logic                oRdValid,
  output logic [DATA_W-1:0]   oRdData,
  output logic [SEL_W-1:0]    oRdSel,
  input  logic                iRdReady
);
  rdState_t                       state;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0]              muxData;
  logic [DATA_W-1:0]              loadData;
  logic                           accept;

  assign regs = {iR7, iR6, iR5, iR4, iR3, iR2, iR1, iR0};

  reg_mux8 #(.DATA_W(DATA_W)) uMux (
    .iRegs (regs),
    .iSel  (iReqSel),
    .oData (muxData)
  );

`ifdef REG_READ_BYPASS_EN
  // Only the write to the register being read matters; other enable bits
  // may be set at the same time.
  assign loadData = iWrEn[iReqSel] ? iWrData : muxData;
`else
  logic unusedWr;
  assign unusedWr = ^{iWrEn, iWrData};
  assign loadData = muxData;
`endif

  // Buffer can take a new read when empty or when its entry drains this cycle.
  assign oReqReady = ~oRdValid | iRdReady;
  assign accept    = iReqValid & oReqReady;

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state    <= EMPTY;
      oRdValid <= 1'b0;
      oRdData  <= '0;
      oRdSel   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            oRdData  <= loadData;
            oRdSel   <= iReqSel;
            oRdValid <= 1'b1;
            state    <= FULL;
          end
        end
        FULL: begin
          if (accept) begin
            // Drain and reload on the same edge: one read per cycle.
            oRdData <= loadData;
            oRdSel  <= iReqSel;
          end else if (iRdReady) begin
            // Payload keeps its last value once drained.
            oRdValid <= 1'b0;
            state    <= EMPTY;
          end
        end
        default: begin
          oRdValid <= 1'b0;
          state    <= EMPTY;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_reg_read_port.sv
module tb_reg_read_port;
  localparam int DW = 16;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic [DW-1:0] iR0, iR1, iR2, iR3, iR4, iR5, iR6, iR7;
  logic [7:0]    iWrEn;
  logic [DW-1:0] iWrData;
  logic          iReqValid;
  logic [2:0]    iReqSel;
  logic          oReqReady;
  logic          oRdValid;
  logic [DW-1:0] oRdData;
  logic [2:0]    oRdSel;
  logic          iRdReady;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    sel;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;

  reg_read_port #(.DATA_W(DW)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iR0(iR0), .iR1(iR1), .iR2(iR2), .iR3(iR3),
    .iR4(iR4), .iR5(iR5), .iR6(iR6), .iR7(iR7),
    .iWrEn(iWrEn), .iWrData(iWrData),
    .iReqValid(iReqValid), .iReqSel(iReqSel), .oReqReady(oReqReady),
    .oRdValid(oRdValid), .oRdData(oRdData), .oRdSel(oRdSel),
    .iRdReady(iRdReady)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance past the next active edge; inputs change 1 unit after it.
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Issue a request for the coming edge and record what it must return.
  task automatic req(input logic [2:0] sel, input logic [DW-1:0] expData);
    exp_t e;
    iReqValid = 1'b1;
    iReqSel   = sel;
    e.data    = expData;
    e.sel     = sel;
    expQ.push_back(e);
  endtask

  // Monitor: every completed output handshake is checked against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge iClk);
      if (iRst_n && oRdValid && iRdReady) begin
        if (expQ.size() == 0) begin
          chk("unexpected_output", {29'd0, oRdSel}, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          chk("rd_data", {16'd0, oRdData}, {16'd0, e.data});
          chk("rd_sel", {29'd0, oRdSel}, {29'd0, e.sel});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    iRst_n = 1'b0; iReqValid = 1'b1; iReqSel = 3'd3; iRdReady = 1'b0;
    iR0 = '0; iR1 = '0; iR2 = '0; iR3 = 16'hA5A5;
    iR4 = '0; iR5 = '0; iR6 = '0; iR7 = '0;
    iWrEn = '0; iWrData = '0;

    // Reset with a request pending: request ignored, outputs cleared.
    tick(); tick();
    @(negedge iClk);
    chk("rst_valid", {31'd0, oRdValid}, 32'd0);
    chk("rst_data", {16'd0, oRdData}, 32'd0);
    chk("rst_sel", {29'd0, oRdSel}, 32'd0);
    iRst_n = 1'b1; iReqValid = 1'b0;
    @(negedge iClk);
    chk("rst_release_ready", {31'd0, oReqReady}, 32'd1);

    // Basic read with latency 1.
    req(3'd3, 16'hA5A5);
    tick();
    iReqValid = 1'b0;
    @(negedge iClk);
    chk("basic_valid", {31'd0, oRdValid}, 32'd1);
    chk("basic_data", {16'd0, oRdData}, 32'h0000_A5A5);
    chk("basic_sel", {29'd0, oRdSel}, 32'd3);

    // Backpressure: held data is a snapshot, request side blocked.
    iR3 = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge iClk);
      chk("bp_hold_data", {16'd0, oRdData}, 32'h0000_A5A5);
      chk("bp_hold_valid", {31'd0, oRdValid}, 32'd1);
      chk("bp_ready", {31'd0, oReqReady}, 32'd0);
      tick();
    end
    iRdReady = 1'b1;
    tick();
    @(negedge iClk);
    chk("drain_empty", {31'd0, oRdValid}, 32'd0);
    chk("drain_data_kept", {16'd0, oRdData}, 32'h0000_A5A5);

    // Streaming: one read per cycle with consumer always ready.
    iR0 = 16'h0010; iR1 = 16'h0011; iR2 = 16'h0012;
    for (int n = 0; n < 3; n++) begin
      req(n[2:0], 16'h0010 + 16'(n));
      tick();
      iReqValid = 1'b0;
      @(negedge iClk);
      chk("stream_valid", {31'd0, oRdValid}, 32'd1);
    end
    tick();

    // Write to the selected register in the accept cycle.
    iR5 = 16'h1111; iWrEn = 8'h20; iWrData = 16'h2222;
`ifdef REG_READ_BYPASS_EN
    req(3'd5, 16'h2222);
`else
    req(3'd5, 16'h1111);
`endif
    tick();
    // Write to a different register never forwards.
    iWrEn = 8'h01;
    req(3'd5, 16'h1111);
    tick();
    // Several enables set, including the selected one.
    iR6 = 16'h3333; iWrEn = 8'hFF; iWrData = 16'h4444;
`ifdef REG_READ_BYPASS_EN
    req(3'd6, 16'h4444);
`else
    req(3'd6, 16'h3333);
`endif
    tick();
    iReqValid = 1'b0; iWrEn = '0;
    tick();

    // Mid-operation reset discards a held read.
    iRdReady = 1'b0;
    req(3'd3, 16'h0001);
    tick();
    @(negedge iClk);
    chk("mid_full", {31'd0, oRdValid}, 32'd1);
    iRst_n = 1'b0; iReqSel = 3'd2;   // request kept high through reset
    tick();
    void'(expQ.pop_back());
    iRst_n = 1'b1; iReqValid = 1'b0;
    @(negedge iClk);
    chk("mid_rst_valid", {31'd0, oRdValid}, 32'd0);
    chk("mid_rst_data", {16'd0, oRdData}, 32'd0);
    chk("mid_rst_ready", {31'd0, oReqReady}, 32'd1);
    tick();
    @(negedge iClk);
    chk("mid_rst_no_ghost", {31'd0, oRdValid}, 32'd0);

    tick(); tick();
    chk("queue_drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
